view_stream_ctrl: RTL

- Sequencer for the 128-bit view buffer (one parallel load, then byte-serial shift-out, MSB byte first).
- On start, fetches view_count consecutive views from feature memory (address base_addr + k*stride), loads each into the view buffer, then drains 16 bytes per view to the downstream MAC/PE.
- The consumer applies backpressure through out_ready.
- Sits between the feature-memory read port, the view buffer, and the convolution datapath.

---
 rtl/view_pkg.sv | 31 +++
 rtl/view_addr_gen.sv | 52 +++++
 rtl/view_stream_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/view_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : view_pkg
//  Description : Shared geometry constants and FSM state encoding for the
//                view-buffer streaming sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package view_pkg;

  localparam int VIEW_BITS      = 128;
  localparam int BYTE_BITS      = 8;
  localparam int BYTES_PER_VIEW = VIEW_BITS / BYTE_BITS;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_LOAD   = 3'd3;
  localparam logic [2:0] S_STREAM = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_FETCH  = S_FETCH,
    ST_WAIT   = S_WAIT,
    ST_LOAD   = S_LOAD,
    ST_STREAM = S_STREAM,
    ST_DONE   = S_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/view_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : view_addr_gen
//  Description : Holds the current view address and view index for a job;
//                loads on job accept, steps after each drained view, and
//                flags when the current view is the last one.
//  Revision    : 1.0 - initial release
// ============================================================================
module view_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_baseAddr,
  input  logic [ADDR_W-1:0] i_stride,
  input  logic [CNT_W-1:0]  i_viewCount,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_isLast
);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_stride;
  logic [CNT_W-1:0]  r_viewCount;
  logic [CNT_W-1:0]  r_viewIdx;

  // Job parameters latch on load; address and index advance once per view.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_stride    <= '0;
      r_viewCount <= '0;
      r_viewIdx   <= '0;
    end else if (i_load) begin
      r_addr      <= i_baseAddr;
      r_stride    <= i_stride;
      r_viewCount <= i_viewCount;
      r_viewIdx   <= '0;
    end else if (i_step) begin
      r_addr      <= r_addr + r_stride;
      r_viewIdx   <= r_viewIdx + CNT_W'(1);
    end
  end

  // One extra bit so the compare stays exact at the maximum view count.
  assign o_isLast = (({1'b0, r_viewIdx} + (CNT_W + 1)'(1)) == {1'b0, r_viewCount});
  assign o_addr   = r_addr;

endmodule
`default_nettype wire

// File: rtl/view_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : view_stream_ctrl
//  Description : Fetches a run of views from feature memory, loads each into
//                the single-entry view buffer and drains it byte-serially to
//                the MAC/PE under consumer backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module view_stream_ctrl #(
  parameter int BYTES_PER_VIEW = view_pkg::BYTES_PER_VIEW,
  parameter int ADDR_W         = 8,
  parameter int CNT_W          = 8,
  parameter int MEM_LAT        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [CNT_W-1:0]  view_count,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              we_view,
  output logic              re_view,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              last_byte,
  output logic              busy,
  output logic              done
);

  import view_pkg::*;

  localparam int                c_BC_W      = $clog2(BYTES_PER_VIEW);
  localparam logic [c_BC_W-1:0] c_LAST_BYTE = c_BC_W'(BYTES_PER_VIEW - 1);
  localparam logic [2:0]        c_LAT_INIT  = 3'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_nextState;
  state_t            w_fetchNext;
  logic [2:0]        r_latCnt;
  logic [c_BC_W-1:0] r_byteCnt;
  logic              r_outValid;
  logic              r_lastByte;
  logic              w_load;
  logic              w_lastShift;
  logic              w_lastView;

  // A single-cycle memory skips the latency wait entirely.
  generate
    if (MEM_LAT == 1) begin : g_lat1
      assign w_fetchNext = ST_LOAD;
    end else begin : g_latN
      assign w_fetchNext = ST_WAIT;
    end
  endgenerate

  view_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addrGen (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_baseAddr  (base_addr),
    .i_stride    (stride),
    .i_viewCount (view_count),
    .i_step      (w_lastShift),
    .o_addr      (mem_addr),
    .o_isLast    (w_lastView)
  );

  // State register plus latency/byte counters and the registered output flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_latCnt   <= '0;
      r_byteCnt  <= '0;
      r_outValid <= 1'b0;
      r_lastByte <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_FETCH) begin
        r_latCnt <= c_LAT_INIT;
      end else if (r_state == ST_WAIT) begin
        r_latCnt <= r_latCnt - 3'd1;
      end
      if (r_state == ST_LOAD) begin
        r_byteCnt <= '0;
      end else if (re_view) begin
        r_byteCnt <= r_byteCnt + c_BC_W'(1);
      end
      // Buffer output changes on the shift edge, so valid trails re_view.
      r_outValid <= re_view;
      r_lastByte <= w_lastShift && w_lastView;
    end
  end

  // Next-state decode and per-state strobes; the next fetch waits for a full drain.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    mem_rd      = 1'b0;
    we_view     = 1'b0;
    re_view     = 1'b0;
    done        = 1'b0;
    busy        = (r_state != ST_IDLE);
    w_lastShift = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_nextState = (view_count == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_rd      = 1'b1;
        w_nextState = w_fetchNext;
      end
      ST_WAIT: begin
        if (r_latCnt == 3'd1) begin
          w_nextState = ST_LOAD;
        end
      end
      ST_LOAD: begin
        we_view     = 1'b1;
        w_nextState = ST_STREAM;
      end
      ST_STREAM: begin
        re_view     = out_ready;
        w_lastShift = out_ready && (r_byteCnt == c_LAST_BYTE);
        if (w_lastShift) begin
          w_nextState = w_lastView ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  assign out_valid = r_outValid;
  assign last_byte = r_lastByte;

endmodule
`default_nettype wire
